cc_collision_scanner: RTL and testbench

CC_COLLISION_SCANNER -- requirements
Module: cc_collision_scanner

---
 rtl/cc_collision_pkg.sv | 13 +
 rtl/cc_row_and_reduce.sv | 14 +
 rtl/cc_collision_scanner.sv | 139 +++++++++++++
 tb/tb_cc_collision_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_collision_pkg.sv
// Shared definitions for the collision scanner: FSM state encoding and default frame geometry.
package cc_collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } ccState_t;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int DEFAULT_ROWS      = 8;

endpackage

// File: rtl/cc_row_and_reduce.sv
// Combinational per-row overlap: bitwise AND of player and obstacle words plus an OR-reduced hit flag.
module cc_row_and_reduce #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic [NUMBER_DATAWIDTH-1:0] playerRow,
    input  logic [NUMBER_DATAWIDTH-1:0] obstacleRow,
    output logic [NUMBER_DATAWIDTH-1:0] andRow,
    output logic                        rowHit
);

    assign andRow = playerRow & obstacleRow;
    assign rowHit = |andRow;

endmodule

// File: rtl/cc_collision_scanner.sv
// Row-serial collision scanner: snapshots two frames on start, checks one row per cycle, reports on DONE.
// Optional sticky collision flag enabled by defining CC_COLLISION_SCANNER_STICKY_EN.
module cc_collision_scanner
    import cc_collision_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int NUMBER_ROWS      = DEFAULT_ROWS
) (
    input  logic                                    CC_COLLISION_SCANNER_CLOCK_50,
    input  logic                                    CC_COLLISION_SCANNER_RESET_InHigh,
    input  logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] CC_COLLISION_SCANNER_player_InBUS,
    input  logic [NUMBER_ROWS*NUMBER_DATAWIDTH-1:0] CC_COLLISION_SCANNER_obstacle_InBUS,
    input  logic                                    CC_COLLISION_SCANNER_start_In,
    input  logic                                    CC_COLLISION_SCANNER_clear_In,
    output logic                                    CC_COLLISION_SCANNER_busy_Out,
    output logic                                    CC_COLLISION_SCANNER_done_Out,
    output logic                                    CC_COLLISION_SCANNER_collision_Out,
    output logic [$clog2(NUMBER_ROWS)-1:0]          CC_COLLISION_SCANNER_row_OutBUS,
    output logic [$clog2(NUMBER_ROWS+1)-1:0]        CC_COLLISION_SCANNER_count_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0]             CC_COLLISION_SCANNER_mask_OutBUS,
    output ccState_t                                debugState
);

    localparam int RW = $clog2(NUMBER_ROWS);
    localparam int CW = $clog2(NUMBER_ROWS+1);
    localparam int FW = NUMBER_ROWS*NUMBER_DATAWIDTH;

    ccState_t                    state;
    logic [FW-1:0]               playerSnap;
    logic [FW-1:0]               obstacleSnap;
    logic [RW-1:0]               rowPtr;
    logic [RW-1:0]               accRow;
    logic                        accFound;
    logic [CW-1:0]               accCount;
    logic [NUMBER_DATAWIDTH-1:0] accMask;

    logic [NUMBER_DATAWIDTH-1:0] curPlayer;
    logic [NUMBER_DATAWIDTH-1:0] curObstacle;
    logic [NUMBER_DATAWIDTH-1:0] curAnd;
    logic                        curHit;
    logic [RW-1:0]               nextRow;
    logic [CW-1:0]               nextCount;
    logic [NUMBER_DATAWIDTH-1:0] nextMask;
    logic                        lastRow;

    assign curPlayer   = playerSnap[int'(rowPtr)*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
    assign curObstacle = obstacleSnap[int'(rowPtr)*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];

    cc_row_and_reduce #(
        .NUMBER_DATAWIDTH(NUMBER_DATAWIDTH)
    ) rowReduce (
        .playerRow  (curPlayer),
        .obstacleRow(curObstacle),
        .andRow     (curAnd),
        .rowHit     (curHit)
    );

    // Accumulator values including the row being evaluated this cycle; the first hit fixes the row index.
    always_comb begin
        nextRow   = accRow;
        nextCount = accCount + CW'(curHit);
        nextMask  = accMask | curAnd;
        lastRow   = (rowPtr == RW'(NUMBER_ROWS-1));
        if (curHit && !accFound) begin
            nextRow = rowPtr;
        end
    end

    assign debugState = state;

    always_ff @(posedge CC_COLLISION_SCANNER_CLOCK_50 or posedge CC_COLLISION_SCANNER_RESET_InHigh) begin
        if (CC_COLLISION_SCANNER_RESET_InHigh) begin
            state                              <= ST_IDLE;
            playerSnap                         <= '0;
            obstacleSnap                       <= '0;
            rowPtr                             <= '0;
            accRow                             <= '0;
            accFound                           <= 1'b0;
            accCount                           <= '0;
            accMask                            <= '0;
            CC_COLLISION_SCANNER_busy_Out      <= 1'b0;
            CC_COLLISION_SCANNER_done_Out      <= 1'b0;
            CC_COLLISION_SCANNER_collision_Out <= 1'b0;
            CC_COLLISION_SCANNER_row_OutBUS    <= '0;
            CC_COLLISION_SCANNER_count_OutBUS  <= '0;
            CC_COLLISION_SCANNER_mask_OutBUS   <= '0;
        end else begin
`ifdef CC_COLLISION_SCANNER_STICKY_EN
            // A set on the DONE edge below overrides this clear.
            if (CC_COLLISION_SCANNER_clear_In) begin
                CC_COLLISION_SCANNER_collision_Out <= 1'b0;
            end
`endif
            case (state)
                ST_SCAN: begin
                    accRow   <= nextRow;
                    accFound <= accFound | curHit;
                    accCount <= nextCount;
                    accMask  <= nextMask;
                    if (lastRow) begin
                        state                             <= ST_DONE;
                        CC_COLLISION_SCANNER_busy_Out     <= 1'b0;
                        CC_COLLISION_SCANNER_done_Out     <= 1'b1;
                        CC_COLLISION_SCANNER_row_OutBUS   <= nextRow;
                        CC_COLLISION_SCANNER_count_OutBUS <= nextCount;
                        CC_COLLISION_SCANNER_mask_OutBUS  <= nextMask;
`ifdef CC_COLLISION_SCANNER_STICKY_EN
                        if (nextCount != '0) begin
                            CC_COLLISION_SCANNER_collision_Out <= 1'b1;
                        end
`else
                        CC_COLLISION_SCANNER_collision_Out <= (nextCount != '0);
`endif
                    end else begin
                        rowPtr <= rowPtr + 1'b1;
                    end
                end
                default: begin
                    CC_COLLISION_SCANNER_done_Out <= 1'b0;
                    if (CC_COLLISION_SCANNER_start_In) begin
                        state                         <= ST_SCAN;
                        playerSnap                    <= CC_COLLISION_SCANNER_player_InBUS;
                        obstacleSnap                  <= CC_COLLISION_SCANNER_obstacle_InBUS;
                        rowPtr                        <= '0;
                        accRow                        <= '0;
                        accFound                      <= 1'b0;
                        accCount                      <= '0;
                        accMask                       <= '0;
                        CC_COLLISION_SCANNER_busy_Out <= 1'b1;
                    end else begin
                        state                         <= ST_IDLE;
                        CC_COLLISION_SCANNER_busy_Out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_collision_scanner.sv
// Directed bench for cc_collision_scanner at default geometry (8 rows x 8 columns).
module tb_cc_collision_scanner;
    import cc_collision_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] player = '0;
    logic [63:0] obstacle = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic        done;
    logic        collision;
    logic [2:0]  rowIdx;
    logic [3:0]  count;
    logic [7:0]  mask;
    ccState_t    dbgState;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    cc_collision_scanner dut (
        .CC_COLLISION_SCANNER_CLOCK_50      (clk),
        .CC_COLLISION_SCANNER_RESET_InHigh  (rst),
        .CC_COLLISION_SCANNER_player_InBUS  (player),
        .CC_COLLISION_SCANNER_obstacle_InBUS(obstacle),
        .CC_COLLISION_SCANNER_start_In      (start),
        .CC_COLLISION_SCANNER_clear_In      (clear),
        .CC_COLLISION_SCANNER_busy_Out      (busy),
        .CC_COLLISION_SCANNER_done_Out      (done),
        .CC_COLLISION_SCANNER_collision_Out (collision),
        .CC_COLLISION_SCANNER_row_OutBUS    (rowIdx),
        .CC_COLLISION_SCANNER_count_OutBUS  (count),
        .CC_COLLISION_SCANNER_mask_OutBUS   (mask),
        .debugState                         (dbgState)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames_single();
        player = '0;
        obstacle = '0;
        player[3*8 +: 8] = 8'h18;
        obstacle[3*8 +: 8] = 8'h10;
    endtask

    task automatic frames_two();
        player = '0;
        obstacle = '0;
        player[1*8 +: 8] = 8'hFF;
        player[6*8 +: 8] = 8'hFF;
        obstacle[1*8 +: 8] = 8'h81;
        obstacle[6*8 +: 8] = 8'h81;
    endtask

    task automatic frames_disjoint();
        player = {8{8'h0F}};
        obstacle = {8{8'hF0}};
    endtask

    // Pulses start for one edge (edge 1), then waits for done; edges = edge number where done appeared.
    task automatic run_scan(output int edges);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors += 7;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        if (collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision got=%b exp=0", collision); end
        if (rowIdx !== 3'd0) begin miscompares++; $display("FAIL reset_row got=%0d exp=0", rowIdx); end
        if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (mask !== 8'h00) begin miscompares++; $display("FAIL reset_mask got=%h exp=00", mask); end
        if (dbgState !== ST_IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", dbgState, ST_IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_row();
        int edges;
        frames_single();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_after_start got=%b exp=1", busy); end
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            if (edges == 8) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last_row got=%b exp=1", busy); end
            end
        end
        vectors += 6;
        if (edges !== 9) begin miscompares++; $display("FAIL single_done_edge got=%0d exp=9", edges); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        if (collision !== 1'b1) begin miscompares++; $display("FAIL single_collision got=%b exp=1", collision); end
        if (rowIdx !== 3'd3) begin miscompares++; $display("FAIL single_row got=%0d exp=3", rowIdx); end
        if (count !== 4'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
        if (mask !== 8'h10) begin miscompares++; $display("FAIL single_mask got=%h exp=10", mask); end
        // Done lasts one cycle; results hold afterwards.
        tick();
        vectors += 4;
        if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse got=%b exp=0", done); end
        if (dbgState !== ST_IDLE) begin miscompares++; $display("FAIL single_state_idle got=%0d exp=%0d", dbgState, ST_IDLE); end
        if (rowIdx !== 3'd3) begin miscompares++; $display("FAIL single_row_hold got=%0d exp=3", rowIdx); end
        if (mask !== 8'h10) begin miscompares++; $display("FAIL single_mask_hold got=%h exp=10", mask); end
    endtask

    task automatic test_two_rows();
        int edges;
        frames_two();
        run_scan(edges);
        vectors += 5;
        if (edges !== 9) begin miscompares++; $display("FAIL two_done_edge got=%0d exp=9", edges); end
        if (rowIdx !== 3'd1) begin miscompares++; $display("FAIL two_row got=%0d exp=1", rowIdx); end
        if (count !== 4'd2) begin miscompares++; $display("FAIL two_count got=%0d exp=2", count); end
        if (mask !== 8'h81) begin miscompares++; $display("FAIL two_mask got=%h exp=81", mask); end
        if (collision !== 1'b1) begin miscompares++; $display("FAIL two_collision got=%b exp=1", collision); end
        tick();
    endtask

    task automatic test_disjoint();
        int edges;
        logic expColl;
`ifdef CC_COLLISION_SCANNER_STICKY_EN
        expColl = 1'b1;
`else
        expColl = 1'b0;
`endif
        frames_disjoint();
        run_scan(edges);
        vectors += 5;
        if (edges !== 9) begin miscompares++; $display("FAIL disjoint_done_edge got=%0d exp=9", edges); end
        if (rowIdx !== 3'd0) begin miscompares++; $display("FAIL disjoint_row got=%0d exp=0", rowIdx); end
        if (count !== 4'd0) begin miscompares++; $display("FAIL disjoint_count got=%0d exp=0", count); end
        if (mask !== 8'h00) begin miscompares++; $display("FAIL disjoint_mask got=%h exp=00", mask); end
        if (collision !== expColl) begin miscompares++; $display("FAIL disjoint_collision got=%b exp=%b", collision, expColl); end
        tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        frames_single();
        start = 1'b1;
        tick();
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            if (edges == 4) frames_two();
        end
        vectors += 4;
        if (edges !== 9) begin miscompares++; $display("FAIL b2b_first_done_edge got=%0d exp=9", edges); end
        if (rowIdx !== 3'd3) begin miscompares++; $display("FAIL b2b_first_row got=%0d exp=3", rowIdx); end
        if (count !== 4'd1) begin miscompares++; $display("FAIL b2b_first_count got=%0d exp=1", count); end
        if (mask !== 8'h10) begin miscompares++; $display("FAIL b2b_first_mask got=%h exp=10", mask); end
        tick();
        edges = 1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        start = 1'b0;
        vectors += 4;
        if (edges !== 9) begin miscompares++; $display("FAIL b2b_second_done_edge got=%0d exp=9", edges); end
        if (rowIdx !== 3'd1) begin miscompares++; $display("FAIL b2b_second_row got=%0d exp=1", rowIdx); end
        if (count !== 4'd2) begin miscompares++; $display("FAIL b2b_second_count got=%0d exp=2", count); end
        if (mask !== 8'h81) begin miscompares++; $display("FAIL b2b_second_mask got=%h exp=81", mask); end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int edges;
        int seenDone;
        frames_single();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (collision !== 1'b0) begin miscompares++; $display("FAIL midrst_collision got=%b exp=0", collision); end
        if (rowIdx !== 3'd0) begin miscompares++; $display("FAIL midrst_row got=%0d exp=0", rowIdx); end
        if (count !== 4'd0) begin miscompares++; $display("FAIL midrst_count got=%0d exp=0", count); end
        if (mask !== 8'h00) begin miscompares++; $display("FAIL midrst_mask got=%h exp=00", mask); end
        tick();
        rst = 1'b0;
        seenDone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seenDone++;
        end
        vectors++;
        if (seenDone !== 0) begin miscompares++; $display("FAIL midrst_no_done got=%0d exp=0", seenDone); end
        run_scan(edges);
        vectors += 4;
        if (edges !== 9) begin miscompares++; $display("FAIL midrst_rescan_edge got=%0d exp=9", edges); end
        if (rowIdx !== 3'd3) begin miscompares++; $display("FAIL midrst_rescan_row got=%0d exp=3", rowIdx); end
        if (count !== 4'd1) begin miscompares++; $display("FAIL midrst_rescan_count got=%0d exp=1", count); end
        if (collision !== 1'b1) begin miscompares++; $display("FAIL midrst_rescan_collision got=%b exp=1", collision); end
        tick();
    endtask

`ifdef CC_COLLISION_SCANNER_STICKY_EN
    task automatic test_sticky();
        int edges;
        frames_disjoint();
        run_scan(edges);
        vectors++;
        if (collision !== 1'b1) begin miscompares++; $display("FAIL sticky_hold_clean got=%b exp=1", collision); end
        tick();
        clear = 1'b1;
        frames_single();
        run_scan(edges);
        vectors++;
        if (collision !== 1'b1) begin miscompares++; $display("FAIL sticky_set_beats_clear got=%b exp=1", collision); end
        clear = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (collision !== 1'b0) begin miscompares++; $display("FAIL sticky_clear got=%b exp=0", collision); end
    endtask
`else
    task automatic test_clear_ignored();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        vectors++;
        if (collision !== 1'b1) begin miscompares++; $display("FAIL clear_ignored got=%b exp=1", collision); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_row();
        test_two_rows();
        test_disjoint();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef CC_COLLISION_SCANNER_STICKY_EN
        test_sticky();
`else
        test_clear_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
